// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM dead-time stage.
package pwm_pkg;
  localparam int DT_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    HIGH_ON,
    DT_H2L,
    LOW_ON,
    DT_L2H
  } state_t;
endpackage

// File: rtl/pwm_dt_counter.sv
// Loadable dead-time down-counter; saturates at zero and flags it.
module pwm_dt_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (load)             cnt <= din;
    else if (en && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/pwm_deadtime.sv
// Complementary gate-drive pair with dead-time, enable and fault shutdown.
// Define PWM_DEADTIME_FAULT_LATCH_EN to latch faults until Fault_Clr.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DT_WIDTH = DT_WIDTH_DEF
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Enable,
  input  logic                PWM_In,
  input  logic [DT_WIDTH-1:0] DeadTime,
  input  logic                Fault,
  input  logic                Fault_Clr,
  output logic                High_Out,
  output logic                Low_Out,
  output logic                Fault_Active
);
  state_t state, nxt;
  logic   load, clr, dec, zero, blocked, fa_nxt;

`ifdef PWM_DEADTIME_FAULT_LATCH_EN
  // Latched: the registered flag keeps the FSM parked until an explicit clear.
  assign blocked = Fault | Fault_Active;
  assign fa_nxt  = Fault | (Fault_Active & ~Fault_Clr);
`else
  logic unused_fault_clr;
  assign unused_fault_clr = Fault_Clr;
  assign blocked = Fault;
  assign fa_nxt  = Fault;
`endif

  assign dec = (state == DT_H2L) || (state == DT_L2H);

  pwm_dt_counter #(.W(DT_WIDTH)) u_cnt (
    .clk  (Clock),
    .rst  (Reset),
    .clr  (clr),
    .load (load),
    .en   (dec),
    .din  (DeadTime),
    .zero (zero)
  );

  always_comb begin
    nxt  = state;
    load = 1'b0;
    clr  = 1'b0;
    if (blocked || !Enable) begin
      nxt = IDLE;
      clr = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          load = 1'b1;
          nxt  = PWM_In ? DT_L2H : DT_H2L;
        end
        HIGH_ON: if (!PWM_In) begin
          load = 1'b1;
          nxt  = DT_H2L;
        end
        // An early return of the input re-enables the side that was just on.
        DT_H2L: begin
          if (PWM_In)    nxt = HIGH_ON;
          else if (zero) nxt = LOW_ON;
        end
        LOW_ON: if (PWM_In) begin
          load = 1'b1;
          nxt  = DT_L2H;
        end
        DT_L2H: begin
          if (!PWM_In)   nxt = LOW_ON;
          else if (zero) nxt = HIGH_ON;
        end
        default: nxt = IDLE;
      endcase
    end
  end

  // Outputs decode the next state, so both sides can never be high together.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      High_Out     <= 1'b0;
      Low_Out      <= 1'b0;
      Fault_Active <= 1'b0;
    end else begin
      state        <= nxt;
      High_Out     <= (nxt == HIGH_ON);
      Low_Out      <= (nxt == LOW_ON);
      Fault_Active <= fa_nxt;
    end
  end
endmodule
